// File: rtl/mult_div_pkg.sv
// rtl/mult_div_pkg.sv - opcodes, FSM encodings and opcode width shared by mult/div, decoder and hazard unit
package mult_div_pkg;

  localparam int NB_MD_OPCODE = 3;

  localparam logic [NB_MD_OPCODE-1:0] MD_MULT  = 3'b000;
  localparam logic [NB_MD_OPCODE-1:0] MD_MULTU = 3'b001;
  localparam logic [NB_MD_OPCODE-1:0] MD_DIV   = 3'b010;
  localparam logic [NB_MD_OPCODE-1:0] MD_DIVU  = 3'b011;
  localparam logic [NB_MD_OPCODE-1:0] MD_MTHI  = 3'b100;
  localparam logic [NB_MD_OPCODE-1:0] MD_MTLO  = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10
  } md_state_t;

endpackage

// File: rtl/div_iter.sv
// rtl/div_iter.sv - restoring divider step: unsigned remainder/quotient shift registers, one quotient bit per step
module div_iter #(
  parameter int NB_DATA = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic [NB_DATA-1:0] dividend,
  input  logic [NB_DATA-1:0] divisor,
  output logic [NB_DATA-1:0] quotient,
  output logic [NB_DATA-1:0] remainder
);

  logic [NB_DATA-1:0] rem;
  logic [NB_DATA-1:0] quo;
  logic [NB_DATA:0]   partial;
  logic [NB_DATA:0]   trial;

  // The dividend shifts out of quo's MSB while quotient bits shift into its LSB.
  always_comb begin
    partial = {rem, quo[NB_DATA-1]};
    trial   = partial - {1'b0, divisor};
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rem <= '0;
      quo <= '0;
    end else if (load) begin
      rem <= '0;
      quo <= dividend;
    end else if (step) begin
      if (!trial[NB_DATA]) begin
        rem <= trial[NB_DATA-1:0];
        quo <= {quo[NB_DATA-2:0], 1'b1};
      end else begin
        rem <= partial[NB_DATA-1:0];
        quo <= {quo[NB_DATA-2:0], 1'b0};
      end
    end
  end

  assign quotient  = quo;
  assign remainder = rem;

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU into HI/LO plus MTHI/MTLO, with busy/done handshake.
// Define MULT_DIV_FAST_MULT_EN for a single-cycle multiply; divide stays iterative.
module mult_div_unit #(
  parameter int NB_DATA      = 32,
  parameter int NB_MD_OPCODE = 3
) (
  input  logic                    i_clock,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic [NB_MD_OPCODE-1:0] i_opcode,
  input  logic [NB_DATA-1:0]      i_first_operator,
  input  logic [NB_DATA-1:0]      i_second_operator,
  input  logic                    i_flush,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [NB_DATA-1:0]      o_hi,
  output logic [NB_DATA-1:0]      o_lo
);
  import mult_div_pkg::*;

  localparam int NB_CNT = $clog2(NB_DATA + 1);

  md_state_t            state, next_state;
  logic [NB_CNT-1:0]    count;
  logic                 op_div, sign_q, sign_r;
  logic [NB_DATA-1:0]   mag_a, mag_b, raw_a;
  logic                 req_mult, req_div, req_signed, sa, sb, idle_req;
  logic                 start_md, start_mthi, start_mtlo, run_step, write_res;
  logic [NB_DATA-1:0]   in_mag_a, in_mag_b;
  logic [NB_DATA-1:0]   quotient, remainder, quo_fix, rem_fix, res_hi, res_lo;
  logic [2*NB_DATA-1:0] prod;
`ifndef MULT_DIV_FAST_MULT_EN
  logic [2*NB_DATA-1:0] acc;
  logic [NB_DATA:0]     mult_sum;
`endif

  always_comb begin
    req_mult   = (i_opcode == MD_MULT) || (i_opcode == MD_MULTU);
    req_div    = (i_opcode == MD_DIV)  || (i_opcode == MD_DIVU);
    req_signed = (i_opcode == MD_MULT) || (i_opcode == MD_DIV);
    sa         = req_signed & i_first_operator[NB_DATA-1];
    sb         = req_signed & i_second_operator[NB_DATA-1];
    in_mag_a   = sa ? -i_first_operator  : i_first_operator;
    in_mag_b   = sb ? -i_second_operator : i_second_operator;
    idle_req   = (state == ST_IDLE) && i_start && !i_flush;
    start_md   = idle_req && (req_mult || req_div);
    start_mthi = idle_req && (i_opcode == MD_MTHI);
    start_mtlo = idle_req && (i_opcode == MD_MTLO);
    run_step   = (state == ST_RUN) && !i_flush;
    write_res  = (state == ST_FIX) && !i_flush;
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) state <= ST_IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (start_md) begin
`ifdef MULT_DIV_FAST_MULT_EN
          next_state = req_mult ? ST_FIX : ST_RUN;
`else
          next_state = ST_RUN;
`endif
        end
      end
      ST_RUN: begin
        if (i_flush)                      next_state = ST_IDLE;
        else if (count == NB_CNT'(1))     next_state = ST_FIX;
      end
      ST_FIX:  next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  div_iter #(.NB_DATA(NB_DATA)) u_div_iter (
    .clock     (i_clock),
    .reset     (i_reset),
    .load      (start_md),
    .step      (run_step && op_div),
    .dividend  (in_mag_a),
    .divisor   (mag_b),
    .quotient  (quotient),
    .remainder (remainder)
  );

  always_comb begin
`ifdef MULT_DIV_FAST_MULT_EN
    prod = {{NB_DATA{1'b0}}, mag_a} * {{NB_DATA{1'b0}}, mag_b};
`else
    mult_sum = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, mag_a} : '0);
    prod     = acc;
`endif
    if (sign_q) prod = -prod;
    quo_fix = sign_q ? -quotient  : quotient;
    rem_fix = sign_r ? -remainder : remainder;
    res_hi  = prod[2*NB_DATA-1:NB_DATA];
    res_lo  = prod[NB_DATA-1:0];
    // Divide by zero reports the untouched dividend regardless of signedness.
    if (op_div) begin
      if (mag_b == '0) begin
        res_hi = raw_a;
        res_lo = '1;
      end else begin
        res_hi = rem_fix;
        res_lo = quo_fix;
      end
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      o_hi   <= '0;
      o_lo   <= '0;
      o_busy <= 1'b0;
      o_done <= 1'b0;
      count  <= '0;
      op_div <= 1'b0;
      sign_q <= 1'b0;
      sign_r <= 1'b0;
      mag_a  <= '0;
      mag_b  <= '0;
      raw_a  <= '0;
`ifndef MULT_DIV_FAST_MULT_EN
      acc    <= '0;
`endif
    end else begin
      o_busy <= (next_state != ST_IDLE);
      o_done <= write_res;
      if (start_md) begin
        count  <= NB_CNT'(NB_DATA);
        op_div <= req_div;
        sign_q <= sa ^ sb;
        sign_r <= sa;
        mag_a  <= in_mag_a;
        mag_b  <= in_mag_b;
        raw_a  <= i_first_operator;
`ifndef MULT_DIV_FAST_MULT_EN
        acc    <= {{NB_DATA{1'b0}}, in_mag_b};
`endif
      end else if (run_step) begin
        count <= count - NB_CNT'(1);
`ifndef MULT_DIV_FAST_MULT_EN
        if (!op_div) acc <= {mult_sum, acc[NB_DATA-1:1]};
`endif
      end
      if (write_res) begin
        o_hi <= res_hi;
        o_lo <= res_lo;
      end else begin
        if (start_mthi) o_hi <= i_first_operator;
        if (start_mtlo) o_lo <= i_first_operator;
      end
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit: directed MULT/DIV/MT vectors, flush and reset aborts
module tb_mult_div_unit;

  logic        clk;
  logic        rst;
  logic        start;
  logic [2:0]  opcode;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        busy;
  logic        done;
  logic [31:0] hi;
  logic [31:0] lo;

  int compared = 0;
  int errors   = 0;

  logic [63:0] exp_q[$];
  string       name_q[$];
  logic [63:0] mon_exp;
  string       mon_name;

`ifdef MULT_DIV_FAST_MULT_EN
  localparam int MLAT = 2;
`else
  localparam int MLAT = 34;
`endif
  localparam int DLAT = 34;

  mult_div_unit #(.NB_DATA(32), .NB_MD_OPCODE(3)) dut (
    .i_clock           (clk),
    .i_reset           (rst),
    .i_start           (start),
    .i_opcode          (opcode),
    .i_first_operator  (op_a),
    .i_second_operator (op_b),
    .i_flush           (flush),
    .o_busy            (busy),
    .o_done            (done),
    .o_hi              (hi),
    .o_lo              (lo)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Monitor: every o_done cycle consumes exactly one expected {HI,LO}.
  always @(negedge clk) begin
    if (done) begin
      if (exp_q.size() == 0) begin
        compared++;
        errors++;
        $display("FAIL unexpected_done: got o_done=1 hi=%h lo=%h, required no pending result", hi, lo);
      end else begin
        mon_exp  = exp_q.pop_front();
        mon_name = name_q.pop_front();
        check(mon_name, {hi, lo}, mon_exp);
      end
    end
  end

  // Caller is at a negedge; returns at the negedge of the o_done cycle.
  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                        input int lat, input bit intrude);
    int n;
    int nb;
    exp_q.push_back({eh, el});
    name_q.push_back(name);
    start = 1'b1; opcode = op; op_a = a; op_b = b;
    @(posedge clk); #1 start = 1'b0;
    n = 0; nb = 0;
    do begin
      @(negedge clk);
      n++;
      if (busy) nb++;
      if (intrude && n == 3) begin
        start = 1'b1; opcode = 3'b001; op_a = 32'd6; op_b = 32'd7;
      end
      if (intrude && n == 4) start = 1'b0;
    end while (!done && n < 200);
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_busy_cycles"}, 64'(nb), 64'(lat - 1));
  endtask

  task automatic mt(input string name, input logic [2:0] op, input logic [31:0] d,
                    input logic [31:0] eh, input logic [31:0] el);
    start = 1'b1; opcode = op; op_a = d; op_b = 32'h0;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check(name, {hi, lo}, {eh, el});
    check({name, "_busy_done"}, {62'd0, busy, done}, 64'd0);
  endtask

  task automatic count_no_done(input string name, input int cycles);
    int nd;
    nd = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done) nd++;
    end
    check(name, 64'(nd), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; opcode = 3'b0; op_a = '0; op_b = '0; flush = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state", {hi, lo, 30'd0, busy, done}, 96'd0);
    rst = 1'b0;
    @(negedge clk);

    run_op("mult_neg3x5",   3'b000, 32'hFFFFFFFD, 32'h5,        32'hFFFFFFFF, 32'hFFFFFFF1, MLAT, 0);
    run_op("multu_max_x2",  3'b001, 32'hFFFFFFFF, 32'h2,        32'h00000001, 32'hFFFFFFFE, MLAT, 0);
    run_op("div_neg7by2",   3'b010, 32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, DLAT, 0);
    run_op("divu_7by0",     3'b011, 32'h7,        32'h0,        32'h00000007, 32'hFFFFFFFF, DLAT, 0);
    run_op("div_min_by_m1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, DLAT, 0);
    mt("mthi_in_done_cycle", 3'b100, 32'hABCD1234, 32'hABCD1234, 32'h80000000);

    run_op("div_neg7by0",   3'b010, 32'hFFFFFFF9, 32'h0,        32'hFFFFFFF9, 32'hFFFFFFFF, DLAT, 0);
    run_op("div_7by_neg2",  3'b010, 32'h7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, DLAT, 0);
    run_op("mult_neg4xneg6",3'b000, 32'hFFFFFFFC, 32'hFFFFFFFA, 32'h00000000, 32'h00000018, MLAT, 0);
    run_op("mult_min_sq",   3'b000, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, MLAT, 0);
    run_op("mult_6x7",      3'b000, 32'h6,        32'h7,        32'h00000000, 32'h0000002A, MLAT, 0);
    run_op("divu_100by7_intrude", 3'b011, 32'd100, 32'd7,       32'h00000002, 32'h0000000E, DLAT, 1);

    @(negedge clk);
    mt("ignored_op110", 3'b110, 32'hDEADBEEF, 32'h00000002, 32'h0000000E);
    mt("mthi_preload",  3'b100, 32'h11111111, 32'h11111111, 32'h0000000E);
    mt("mtlo_preload",  3'b101, 32'h11111111, 32'h11111111, 32'h11111111);

    start = 1'b1; opcode = 3'b000; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_hilo", {hi, lo}, {32'h11111111, 32'h11111111});
    count_no_done("flush_no_done", 40);
    check("flush_hilo_after", {hi, lo}, {32'h11111111, 32'h11111111});

    start = 1'b1; opcode = 3'b000; op_a = 32'd2; op_b = 32'd3;
    @(posedge clk); #1 start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    check("reset_async", {hi, lo, 30'd0, busy, done}, 96'd0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("reset_mid_op", {hi, lo, 30'd0, busy, done}, 96'd0);
    count_no_done("reset_no_done", 40);

    run_op("multu_after_reset", 3'b001, 32'd3, 32'd5, 32'h00000000, 32'h0000000F, MLAT, 0);
    repeat (3) @(negedge clk);
    check("pending_results", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Iterative multiply/divide unit in the execute stage, fed the same two operands the ALU receives from the ID/EX register. It executes MULT, MULTU, DIV and DIVU over several cycles into private HI/LO registers, and services MTHI and MTLO. It drives a busy flag that the hazard unit uses to stall the pipeline. HI/LO are exported for the MFHI/MFLO path, which is muxed into the execute-stage result alongside the ALU output.

## Interface
- NB_DATA, 32, operand and HI/LO width (even, ≥ 8)
- NB_MD_OPCODE, 3, operation select width
- i_clock  in  1  rising-edge clock
- i_reset  in  1  asynchronous, active-high reset
- i_start  in  1  request strobe, sampled on the rising edge
- i_opcode  in  NB_MD_OPCODE  operation, sampled with i_start
- i_first_operator  in  NB_DATA  rs: multiplicand, dividend, or MTHI/MTLO data
- i_second_operator  in  NB_DATA  rt: multiplier or divisor
- i_flush  in  1  abort any in-flight operation
- o_busy  out  1  operation in progress; the hazard unit stalls on it
- o_done  out  1  one-cycle pulse when HI/LO hold a new MULT/DIV result
- o_hi  out  NB_DATA  HI register
- o_lo  out  NB_DATA  LO register

## Operation
- Opcodes: MULT=000, MULTU=001, DIV=010, DIVU=011, MTHI=100, MTLO=101. 110 and 111 are ignored.
- States: IDLE, RUN, FIX.
- IDLE → RUN on i_start with a MULT/DIV opcode:
  - latch the opcode and operand magnitudes (absolute values for signed ops);
  - latch the result sign (mult: sa^sb; quotient: sa^sb; remainder: sa);
  - load the counter with NB_DATA.
- MTHI/MTLO in IDLE write o_hi/o_lo on the same edge. No busy, no o_done.
- RUN, one bit per cycle:
  - Multiply: shift-add into a 2·NB_DATA accumulator.
  - Divide: restoring division, producing one quotient bit per cycle.
  - Counter decrements; at 0 → FIX.
- FIX: apply two's-complement correction for negative results, write HI/LO, → IDLE.
- Result placement: mult writes HI = upper half, LO = lower half; div writes LO = quotient, HI = remainder.
- Divide by zero: LO = all ones, HI = dividend (unmodified i_first_operator), for both DIV and DIVU.
- Overflow case: DIV of the most negative value by -1 gives LO = most negative value, HI = 0.
- i_start while busy is ignored; all requests are ignored. The pipeline guarantees this does not occur.
- i_flush in RUN or FIX:
  - → IDLE on the next edge;
  - HI/LO keep their previous values; no o_done.
  - i_flush has priority over i_start in the same cycle.
- Reset:
  - o_hi = 0, o_lo = 0, o_busy = 0, o_done = 0;
  - state IDLE, counter 0.
  - Reset mid-operation discards it.

## Timing
- i_start sampled at edge E0. o_busy is high from after E0 through the edge that writes HI/LO.
- Iterative path:
  - RUN spans NB_DATA edges; FIX writes HI/LO at edge E0+NB_DATA+1.
  - o_done is high in the cycle following that edge, together with the new o_hi/o_lo. Total latency is 34 cycles for NB_DATA = 32.
- o_busy is registered and must fall in the same cycle o_done rises.
- A new i_start is accepted in the o_done cycle.
- MTHI/MTLO latency: 1 edge.

## Configuration
- MULT_DIV_FAST_MULT_EN defined:
  - MULT/MULTU compute a single-cycle signed/unsigned product from the latched operands;
  - RUN is skipped; HI/LO are written at E0+1; o_done pulses the following cycle.
  - Divide behaviour is unchanged.
- Undefined: all ops use the iterative path. The multiply datapath synthesizes no multiplier.

## Structure
- Shared package/include mult_div_pkg holds the opcode localparams, state encodings (IDLE=2'b00, RUN=2'b01, FIX=2'b10), and NB_MD_OPCODE. The decoder and hazard unit include it too.
- One sub-module, div_iter: a restoring-division step holding remainder/quotient shift registers plus a load/step interface.
- The multiply path and the control FSM stay in mult_div_unit.

## Test plan
- MULT -3 × 5 (0xFFFFFFFD, 0x5) → after 34 cycles o_done=1, HI=0xFFFFFFFF, LO=0xFFFFFFF1; o_busy high for exactly 33 cycles.
- MULTU 0xFFFFFFFF × 0x2 → HI=0x00000001, LO=0xFFFFFFFE.
- DIV -7 / 2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU 7 / 0 → LO=0xFFFFFFFF, HI=0x00000007.
- DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0; then MTHI 0xABCD1234 in the o_done cycle → HI=0xABCD1234 one edge later.
- Preload HI=LO=0x11111111. Start MULT 2×3, flush at cycle 10 → o_busy low next cycle, no o_done, HI/LO still 0x11111111. Repeat with i_reset at cycle 10 → all outputs 0.
- With MULT_DIV_FAST_MULT_EN defined: MULT 6×7 → LO=0x2A, HI=0, o_done at E0+2; a concurrent i_start during a DIV is ignored.
